qc_row_accumulator: RTL

Per-block-row XOR accumulator that sits directly downstream of the pipelined circular shifter in the QC-LDPC datapath. Each rotated Z-bit sub-block leaving the shifter is XORed into one of NUM_ROWS accumulators selected by a row tag travelling alongside it. At frame end the accumulated block-row sums (syndrome or parity partials) are drained in row order over a valid/ready output port.

---
 rtl/qc_row_accumulator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/qc_row_accumulator.sv
// Per-block-row XOR accumulator behind the QC-LDPC circular shifter.
// Rotated sub-blocks are folded into NUM_ROWS accumulators and drained in row order at frame end.

module qc_row_acc_lane #(
    parameter int MAXZ = 81
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            xor_en_i,
    input  logic [MAXZ-1:0] data_i,
    output logic [MAXZ-1:0] acc_o
);
    logic [MAXZ-1:0] acc_q, acc_d;

    // Clear and load in the same cycle yields the fresh beat, which is how a frame starts.
    always_comb begin
        acc_d = acc_q;
        if (clr_i)    acc_d = '0;
        if (xor_en_i) acc_d = acc_d ^ data_i;
    end

    always_ff @(posedge CLK) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

module qc_row_accumulator #(
    parameter int MAXZ     = 81,
    parameter int NUM_ROWS = 12,
    parameter int ROW_W    = $clog2(NUM_ROWS),
    parameter int ZW       = $clog2(MAXZ + 1)
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [MAXZ-1:0]  in_data,
    input  logic [ROW_W-1:0] in_row,
    input  logic             first_in,
    input  logic             frame_end,
    input  logic [ZW-1:0]    z_size,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAXZ-1:0]  out_data,
    output logic [ROW_W-1:0] out_row,
    output logic             out_last,
    output logic             busy,
    output logic             err
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [ZW-1:0]    ZMAX     = ZW'(MAXZ);

    state_t                          state_q, state_d;
    logic [ROW_W-1:0]                drain_idx_q, drain_idx_d;
    logic [ZW-1:0]                   zl_q, zl_d;
    logic                            err_q, err_d;

    logic                            row_ok;
    logic                            clr_all;
    logic                            wr_en;
    logic                            use_new_z;
    logic [ZW-1:0]                   z_in_eff;
    logic [ZW-1:0]                   mask_z;
    logic [MAXZ-1:0]                 mask;
    logic [MAXZ-1:0]                 din_m;
    logic [NUM_ROWS-1:0][MAXZ-1:0]   acc;

    assign row_ok   = (32'(in_row) < NUM_ROWS);
    assign z_in_eff = (z_size == '0 || 32'(z_size) > MAXZ) ? ZMAX : z_size;
    // The first beat of a frame must be masked with its own z_size, not the stale latched one.
    assign mask_z   = use_new_z ? z_in_eff : zl_q;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAXZ; i++)
            mask[i] = (32'(i) < 32'(mask_z));
    end

    assign din_m = in_data & mask;

    always_comb begin
        state_d     = state_q;
        drain_idx_d = drain_idx_q;
        zl_d        = zl_q;
        err_d       = err_q;
        clr_all     = 1'b0;
        wr_en       = 1'b0;
        use_new_z   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    if (first_in) begin
                        clr_all     = 1'b1;
                        use_new_z   = 1'b1;
                        zl_d        = z_in_eff;
                        wr_en       = row_ok;
                        drain_idx_d = '0;
                        state_d     = frame_end ? S_DRAIN : S_ACCUM;
                        if (!row_ok) err_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                if (valid_in) begin
                    wr_en = row_ok;
                    if (!row_ok) err_d = 1'b1;
                    if (first_in) begin
                        clr_all   = 1'b1;
                        use_new_z = 1'b1;
                        zl_d      = z_in_eff;
                        err_d     = 1'b1;
                    end
                end
                if (frame_end) begin
                    state_d     = S_DRAIN;
                    drain_idx_d = '0;
                end
            end
            S_DRAIN: begin
                if (valid_in) err_d = 1'b1;
                if (out_ready) begin
                    if (drain_idx_q == LAST_ROW) begin
                        state_d     = S_IDLE;
                        drain_idx_d = '0;
                    end else begin
                        drain_idx_d = drain_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_idx_q <= '0;
            zl_q        <= ZMAX;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_idx_q <= drain_idx_d;
            zl_q        <= zl_d;
            err_q       <= err_d;
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
        qc_row_acc_lane #(.MAXZ(MAXZ)) u_lane (
            .CLK      (CLK),
            .rst      (rst),
            .clr_i    (clr_all),
            .xor_en_i (wr_en && (in_row == ROW_W'(r))),
            .data_i   (din_m),
            .acc_o    (acc[r])
        );
    end

    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = out_valid ? acc[drain_idx_q] : '0;
    assign out_row   = drain_idx_q;
    assign out_last  = out_valid && (drain_idx_q == LAST_ROW);
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
endmodule
